// File: rtl/btn_run_ctrl.sv
// Start/stop control stage: debounces start/stop and direction buttons, runs IDLE/RUN/PAUSE,
// and emits a one-cycle count-enable tick plus direction level. Build option: AUTO_START_EN.
module btn_run_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DIV_SLOW   = 100_000_000,
    parameter int DIV_FAST   = 25_000_000
) (
    input  logic       clk_in_i,
    input  logic       rst_i,
    input  logic       btn_ss_i,
    input  logic       btn_ud_i,
    input  logic       sel_freq_i,
    output logic       tick_o,
    output logic       ud_o,
    output logic       run_o,
    output logic [1:0] state_o
);

    // state | meaning: IDLE 00 stopped, div cleared | RUN 01 dividing | PAUSE 10 div held; 11 -> IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int VW      = $clog2(DIV_MAX + 1);
    localparam int DW      = $clog2(DEB_CYCLES + 1);

    localparam logic [VW-1:0] LIM_SLOW = VW'(DIV_SLOW - 1);
    localparam logic [VW-1:0] LIM_FAST = VW'(DIV_FAST - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

`ifdef AUTO_START_EN
    localparam state_t ST_RESET = S_RUN;
`else
    localparam state_t ST_RESET = S_IDLE;
`endif

    // bit 0 = start/stop, bit 1 = direction, bit 2 = rate select
    logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         lvl_q, lvl_d, lvl_dly_q, lvl_dly_d, press_q, press_d;
    state_t             state_q, state_d;
    logic               ud_q, ud_d, tick_q, tick_d;
    logic [VW-1:0]      div_cnt_q, div_cnt_d, div_lim;

    assign div_lim = sync2_q[2] ? LIM_FAST : LIM_SLOW;

    always_comb begin : debounce
        sync1_d   = {sel_freq_i, btn_ud_i, btn_ss_i};
        sync2_d   = sync1_q;
        lvl_dly_d = lvl_q;
        press_d   = lvl_q & ~lvl_dly_q;
        deb_cnt_d = deb_cnt_q;
        lvl_d     = lvl_q;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] == lvl_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (deb_cnt_q[b] == DEB_LAST) begin
                lvl_d[b]     = sync2_q[b];
                deb_cnt_d[b] = '0;
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
            end
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        ud_d      = ud_q ^ press_q[1];
        case (state_q)
            S_IDLE: begin
                div_cnt_d = '0;
                if (press_q[0]) state_d = S_RUN;
            end
            S_RUN: begin
                // >= so a switch to the fast rate past its limit wraps immediately
                if (div_cnt_q >= div_lim) begin
                    tick_d    = 1'b1;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + VW'(1);
                end
                if (press_q[0]) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (press_q[0]) state_d = S_RUN;
            end
            default: begin
                state_d   = S_IDLE;
                div_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in_i) begin
        if (rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_cnt_q <= '0;
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            press_q   <= '0;
            state_q   <= ST_RESET;
            ud_q      <= 1'b1;
            tick_q    <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_dly_d;
            press_q   <= press_d;
            state_q   <= state_d;
            ud_q      <= ud_d;
            tick_q    <= tick_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign tick_o  = tick_q;
    assign ud_o    = ud_q;
    assign run_o   = (state_q == S_RUN);
    assign state_o = state_q;

endmodule

// File: tb/tb_btn_run_ctrl.sv
// Bench for btn_run_ctrl: random button/rate/reset stimulus, a window-based reference model,
// and a scoreboard that matches every DUT tick and state/direction change against it.
module tb_btn_run_ctrl;

    localparam int DEB   = 4;
    localparam int DSLOW = 10;
    localparam int DFAST = 4;

`ifdef AUTO_START_EN
    localparam int RST_ST = 1;
`else
    localparam int RST_ST = 0;
`endif

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_ss   = 1'b0;
    logic       btn_ud   = 1'b0;
    logic       sel_freq = 1'b0;
    logic       tick, ud, run;
    logic [1:0] state;

    btn_run_ctrl #(
        .DEB_CYCLES(DEB),
        .DIV_SLOW  (DSLOW),
        .DIV_FAST  (DFAST)
    ) dut (
        .clk_in_i  (clk_in),
        .rst_i     (rst),
        .btn_ss_i  (btn_ss),
        .btn_ud_i  (btn_ud),
        .sel_freq_i(sel_freq),
        .tick_o    (tick),
        .ud_o      (ud),
        .run_o     (run),
        .state_o   (state)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int cyc;
        int st;
        int ud;
    } ev_t;

    ev_t ev_q[$];
    int  tick_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a level flips once the last DEB synchronized samples all disagree with it.
    int      m_st  = RST_ST;
    int      m_ud  = 1;
    int      m_div = 0;
    bit      m_tick = 1'b0;
    bit [1:0] m_lvl = '0, m_rose = '0, m_press = '0;
    logic [2:0] m_raw[$];
    bit      w_ss[$], w_ud[$];
    int      p_st = RST_ST;
    int      p_ud = 1;

    function automatic bit settled(input bit w[$], input bit v);
        if (w.size() != DEB) return 1'b0;
        foreach (w[i]) if (w[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk_in) begin : model
        logic [2:0] s;
        int n;
        cyc++;
        if (rst) begin
            m_st    = RST_ST;
            m_ud    = 1;
            m_div   = 0;
            m_tick  = 1'b0;
            m_lvl   = '0;
            m_rose  = '0;
            m_press = '0;
            m_raw.delete();
            m_raw.push_back(3'b000);
            m_raw.push_back(3'b000);
            w_ss.delete();
            w_ud.delete();
        end else begin
            s = m_raw[0];
            n = s[2] ? DFAST : DSLOW;
            m_tick = (m_st == 1) && (m_div >= n - 1);
            if (m_st == 0)      m_div = 0;
            else if (m_st == 1) m_div = m_tick ? 0 : m_div + 1;
            if (m_press[0]) m_st = (m_st == 1) ? 2 : 1;
            if (m_press[1]) m_ud = 1 - m_ud;
            m_press = m_rose;
            m_rose  = '0;
            w_ss.push_back(s[0]);
            if (w_ss.size() > DEB) void'(w_ss.pop_front());
            w_ud.push_back(s[1]);
            if (w_ud.size() > DEB) void'(w_ud.pop_front());
            if (settled(w_ss, ~m_lvl[0])) begin
                m_lvl[0]  = ~m_lvl[0];
                m_rose[0] = m_lvl[0];
            end
            if (settled(w_ud, ~m_lvl[1])) begin
                m_lvl[1]  = ~m_lvl[1];
                m_rose[1] = m_lvl[1];
            end
            void'(m_raw.pop_front());
            m_raw.push_back({sel_freq, btn_ud, btn_ss});
        end
        if (m_tick) tick_q.push_back(cyc);
        if (m_st != p_st || m_ud != p_ud) begin
            ev_q.push_back('{cyc, m_st, m_ud});
            p_st = m_st;
            p_ud = m_ud;
        end
    end

    bit mon_started = 1'b0;
    logic [3:0] prev_obs;

    always @(negedge clk_in) begin : monitor
        ev_t e;
        logic [3:0] obs;
        if (cyc >= 1) begin
            if (!mon_started) begin
                mon_started = 1'b1;
                chk("reset_state", int'(state), RST_ST);
                chk("reset_run", int'(run), (RST_ST == 1) ? 1 : 0);
                chk("reset_tick", int'(tick), 0);
                chk("reset_ud", int'(ud), 1);
                prev_obs = {2'(RST_ST), (RST_ST == 1), 1'b1};
            end else begin
                while (tick_q.size() > 0 && tick_q[0] < cyc) begin
                    chk("missed_tick_at_cycle", 0, tick_q[0]);
                    void'(tick_q.pop_front());
                end
                if (tick === 1'b1) begin
                    if (tick_q.size() > 0 && tick_q[0] == cyc) begin
                        chk("tick_cycle", cyc, tick_q.pop_front());
                    end else begin
                        chk("unexpected_tick", 1, 0);
                    end
                end
                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    e = ev_q.pop_front();
                    chk("missed_state_ud_change", int'({state, ud}), e.st * 2 + e.ud);
                end
                obs = {state, run, ud};
                if (obs !== prev_obs) begin
                    prev_obs = obs;
                    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                        e = ev_q.pop_front();
                        chk("state_run_ud", int'(obs),
                            e.st * 4 + ((e.st == 1) ? 2 : 0) + e.ud);
                    end else begin
                        chk("unexpected_state_ud_change", int'(obs), -1);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0 || b == 2) btn_ss = v;
        if (b == 1 || b == 2) btn_ud = v;
    endtask

    task automatic hold(input int b, input int hi, input int lo);
        set_btn(b, 1'b1);
        idle(hi);
        set_btn(b, 1'b0);
        idle(lo);
    endtask

    task automatic bounce(input int b, input int n);
        for (int i = 0; i < n; i += 2) begin
            set_btn(b, ((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
            idle(2);
        end
        set_btn(b, 1'b0);
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(50);
        hold(0, 12, 40);
        bounce(0, 20);
        idle(20);
        bounce(1, 20);
        idle(20);
        sel_freq = 1'b1;
        idle(30);
        hold(0, 6, 30);
        hold(1, 6, 10);
        hold(0, 6, 40);
        sel_freq = 1'b0;
        idle(20);
        hold(2, 6, 20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(30);
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 7))
                0, 1: hold(0, $urandom_range(1, 9), $urandom_range(1, 12));
                2:    hold(1, $urandom_range(1, 9), $urandom_range(1, 12));
                3:    hold(2, $urandom_range(3, 8), $urandom_range(4, 12));
                4: begin
                    for (int j = 0; j < $urandom_range(4, 16); j++) begin
                        set_btn($urandom_range(0, 1), 1'($urandom_range(0, 1)));
                        idle($urandom_range(1, 3));
                    end
                    set_btn(2, 1'b0);
                end
                5: begin
                    sel_freq = ~sel_freq;
                    idle($urandom_range(1, 15));
                end
                6: idle($urandom_range(5, 40));
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        idle($urandom_range(1, 2));
                        rst = 1'b0;
                    end
                    idle(3);
                end
            endcase
        end
        set_btn(2, 1'b0);
        idle(40);
        chk("tick_queue_drained", tick_q.size(), 0);
        chk("event_queue_drained", ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
